// File: rtl/cpu_mem_pkg.sv
// Shared memory package: FSM state type, word geometry and address decode
// helpers used by both the instruction and data memories.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

  // Word index of a byte address; caller truncates to its own index width.
  function automatic logic [63:0] word_idx(input logic [63:0] a, input int idx_w);
    logic [63:0] m;
    m = (64'd1 << idx_w) - 64'd1;
    return (a >> BYTE_OFF_W) & m;
  endfunction

  // True when every address bit above the word index is zero.
  function automatic logic in_range(input logic [63:0] a, input int idx_w);
    return (a >> (idx_w + BYTE_OFF_W)) == 64'd0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: synchronous write, asynchronous read.
// DMEM_BYTE_LANE_EN adds a per-byte write mask; otherwise writes cover the whole word.
// The array is named mem so a testbench or loader can preload u_arr.mem directly.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   widx,
  input  logic [DATA_W-1:0]          wdata,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [DATA_W/8-1:0]        be,
`endif
  input  logic [$clog2(DEPTH)-1:0]   ridx,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[ridx];

`ifdef DMEM_BYTE_LANE_EN
  // Lane-masked write: only bytes with be set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end
`else
  // Whole-word write.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end
`endif

endmodule

// File: rtl/data_mem_pipe.sv
// Parametrised data memory with configurable read latency and a stall /
// read_valid handshake for a single-cycle core. RD_LAT=0 gives a combinational
// read with no FSM; otherwise an IDLE/BUSY/DONE FSM counts out the latency.
// Optional feature: DMEM_BYTE_LANE_EN adds the byte_en write mask port.
module data_mem_pipe
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  write_data,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic [DATA_W-1:0]  read_data,
  output logic               read_valid,
  output logic               stall,
  output logic               addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  idx;
  logic              bad;
  logic              wr_slot;
  logic              err_set;
  logic              we;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] rword;

  assign idx = IDX_W'(word_idx(64'(addr), IDX_W));
  assign bad = !in_range(64'(addr), IDX_W) || (addr[1:0] != 2'b00);

  // Bad addresses never touch the array; reset never touches it either.
  assign we = mem_write && wr_slot && !bad && !rst;

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_arr (
    .clk   (clk),
    .we    (we),
    .widx  (idx),
    .wdata (write_data),
`ifdef DMEM_BYTE_LANE_EN
    .be    (byte_en),
`endif
    .ridx  (ridx),
    .rdata (rword)
  );

  generate
    if (RD_LAT == 0) begin : g_comb
      assign wr_slot    = 1'b1;
      assign ridx       = idx;
      assign read_data  = bad ? '0 : rword;
      // A read colliding with a write is dropped.
      assign read_valid = mem_read && !mem_write;
      assign stall      = 1'b0;
      assign err_set    = (mem_write && bad) || (mem_read && bad) || (mem_read && mem_write);
    end else begin : g_fsm
      dmem_state_t       state;
      logic [2:0]        cnt;
      logic [IDX_W-1:0]  addr_q;
      logic              bad_q;
      logic [DATA_W-1:0] rd_q;
      logic              launch;

      assign launch     = (state == IDLE) && mem_read && !mem_write;
      // BUSY ignores all inputs; DONE still accepts a write.
      assign wr_slot    = (state != BUSY);
      assign ridx       = addr_q;
      assign stall      = (state == BUSY) || launch;
      assign read_valid = (state == DONE);
      assign read_data  = rd_q;
      assign err_set    = wr_slot && ((mem_write && bad) || (launch && bad) ||
                                      ((state == IDLE) && mem_read && mem_write));

      // Read FSM: latch the request, count down the latency, sample the array.
      always_ff @(posedge clk) begin
        if (rst) begin
          state  <= IDLE;
          cnt    <= 3'd0;
          addr_q <= '0;
          bad_q  <= 1'b0;
          rd_q   <= '0;
        end else begin
          case (state)
            IDLE: if (launch) begin
              addr_q <= idx;
              bad_q  <= bad;
              cnt    <= 3'(RD_LAT - 1);
              state  <= BUSY;
            end
            BUSY: if (cnt == 3'd0) begin
              rd_q  <= bad_q ? '0 : rword;
              state <= DONE;
            end else begin
              cnt <= cnt - 3'd1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  endgenerate

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          addr_err <= 1'b0;
    else if (err_set) addr_err <= 1'b1;
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: RD_LAT=2 main instance plus an RD_LAT=0
// instance. Expected read words go into a queue at request time and are
// popped when read_valid appears.
module tb_data_mem_pipe;

  localparam int DW = 32, DEP = 32, AW = 32, LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data, read_data;
  logic          read_valid, stall, addr_err;

  logic          b_mem_read, b_mem_write;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_write_data, b_read_data;
  logic          b_read_valid, b_stall, b_addr_err;

`ifdef DMEM_BYTE_LANE_EN
  logic [DW/8-1:0] byte_en, b_byte_en;
`endif

  logic [31:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  data_mem_pipe #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data),
`ifdef DMEM_BYTE_LANE_EN
    .byte_en(byte_en),
`endif
    .read_data(read_data), .read_valid(read_valid), .stall(stall), .addr_err(addr_err)
  );

  data_mem_pipe #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .addr(b_addr), .write_data(b_write_data),
`ifdef DMEM_BYTE_LANE_EN
    .byte_en(b_byte_en),
`endif
    .read_data(b_read_data), .read_valid(b_read_valid), .stall(b_stall), .addr_err(b_addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_write = 1'b1; addr = a; write_data = d;
    @(negedge clk);
    chk("wr_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  // Holds mem_read through DONE, then confirms no second read follows.
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int lat;
    bit got;
    @(posedge clk); #1;
    mem_read = 1'b1; addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
    lat = 0; got = 0;
    while (!got && lat < 16) begin
      @(negedge clk);
      lat++;
      if (read_valid) got = 1;
      else chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
    end
    chk({tag, "_latency"}, lat, LAT + 1);
    chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, "_data"}, read_data, exp_q.pop_front());
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk({tag, "_no_relaunch"}, {30'd0, stall, read_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
    b_mem_read = 1'b0; b_mem_write = 1'b0; b_addr = '0; b_write_data = '0;
`ifdef DMEM_BYTE_LANE_EN
    byte_en = '1; b_byte_en = '1;
`endif
    do_reset();
    @(negedge clk);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_flags", {29'd0, read_valid, stall, addr_err}, 32'd0);
    chk("rst_b_err", {31'd0, b_addr_err}, 32'd0);

    // Preload, then reset: contents must survive.
    for (int i = 0; i < 5; i++) do_write(32'(i * 4), 32'h11111111 * 32'(i + 1));
    do_reset();
    do_read(32'h8, 32'h33333333, "t1");
    chk("t1_err", {31'd0, addr_err}, 32'd0);

    // Write then read back.
    do_write(32'h4, 32'hDEADBEEF);
    do_read(32'h4, 32'hDEADBEEF, "t2");

    // Write during BUSY is ignored.
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'hC;
    exp_q.push_back(32'h44444444);
    @(posedge clk); #1;
    mem_write = 1'b1; write_data = 32'h0;
    @(posedge clk); #1;
    mem_write = 1'b0;
    lat = 0;
    while (!read_valid && lat < 16) begin @(negedge clk); lat++; end
    chk("busy_wr_valid", {31'd0, read_valid}, 32'd1);
    chk("busy_wr_data", read_data, exp_q.pop_front());
    @(posedge clk); #1 mem_read = 1'b0;
    do_read(32'hC, 32'h44444444, "busy_wr_kept");
    chk("busy_wr_err", {31'd0, addr_err}, 32'd0);

    // Out-of-range read returns 0 and sets sticky error.
    do_read(32'h80, 32'h0, "t3_oor");
    chk("t3_err", {31'd0, addr_err}, 32'd1);
    do_read(32'h10, 32'h55555555, "t3_after");
    chk("t3_err_sticky", {31'd0, addr_err}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("t3_err_cleared", {31'd0, addr_err}, 32'd0);
    do_read(32'h6, 32'h0, "t3_misal");
    chk("t3_misal_err", {31'd0, addr_err}, 32'd1);

    // Read + write in the same cycle.
    do_reset();
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h0; write_data = 32'hA5A5A5A5;
    @(negedge clk);
    chk("t4_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("t4_flags", {29'd0, read_valid, stall, addr_err}, 32'd1);

    // Reset during BUSY abandons the read.
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk("t5_busy_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst", {29'd0, read_valid, stall, addr_err}, 32'd0);
    chk("t5_read_data", read_data, 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_no_late_valid", {31'd0, read_valid}, 32'd0);
    do_read(32'h0, 32'hA5A5A5A5, "t5_read");

`ifdef DMEM_BYTE_LANE_EN
    byte_en = '1;
    do_write(32'h8, 32'h33333333);
    byte_en = 4'b0101;
    do_write(32'h8, 32'hFFFFFFFF);
    byte_en = 4'b0000;
    do_write(32'h8, 32'h00000000);
    byte_en = '1;
    do_read(32'h8, 32'h33FF33FF, "t6_lanes");
    chk("t6_err", {31'd0, addr_err}, 32'd0);
`endif

    // RD_LAT=0 instance: combinational read, never stalls.
    @(posedge clk); #1;
    b_mem_write = 1'b1; b_addr = 32'h8; b_write_data = 32'h12345678;
    @(negedge clk);
    chk("l0_wr_stall", {31'd0, b_stall}, 32'd0);
    @(posedge clk); #1;
    b_mem_write = 1'b0; b_mem_read = 1'b1;
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    chk("l0_valid", {30'd0, b_read_valid, b_stall}, 32'd2);
    chk("l0_data", b_read_data, exp_q.pop_front());
    @(posedge clk); #1 b_addr = 32'h80;
    @(negedge clk);
    chk("l0_oor_data", b_read_data, 32'd0);
    @(posedge clk); #1 b_mem_read = 1'b0;
    @(negedge clk);
    chk("l0_err", {30'd0, b_addr_err, b_read_valid}, 32'd2);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
